// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encodings,
// default bit timing and the legal stop-bit range.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  // Below four clocks per bit the FIFO empty flag may not have settled
  // by the time IDLE samples it again.
  localparam int MIN_CLKS_PER_BIT = 4;
  localparam int MIN_STOP_BITS = 1;
  localparam int MAX_STOP_BITS = 2;

  function automatic bit stopBitsLegal(input int n);
    return (n >= MIN_STOP_BITS) && (n <= MAX_STOP_BITS);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle between the FIFO read port / control side and the UART transmitter.
// master = transmitter view, slave = FIFO/controller view.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             tx_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd_en;
  logic             ffi_ready;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (
    input  tx_en, fifo_empty, fifo_dout,
    output fifo_rd_en, ffi_ready, tx, busy, done
  );

  modport slave (
    output tx_en, fifo_empty, fifo_dout,
    input  fifo_rd_en, ffi_ready, tx, busy, done
  );
endinterface

// File: rtl/baud_tick.sv
// Free-running bit-period counter. Restarts from zero on clear or after
// reaching the terminal value, and flags the terminal cycle with a tick.
module baud_tick #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] count_q;

  assign tick_o  = (count_q == term_i);
  assign count_o = count_q;

  // Count up each cycle, restarting at the terminal count or when cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a FIFO read port with 1-cycle read latency.
// Pops one byte in IDLE, captures it in FETCH, then sends start, WIDTH data
// bits LSB-first and STOP_BITS stop bits. Every output comes from a flop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int BIT_W  = $clog2(WIDTH);
  localparam logic [BAUD_W-1:0] BIT_TERM  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_TERM = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);
  // done is registered, so it is armed one cycle before the final stop cycle.
  localparam logic [BAUD_W-1:0] STOP_PRE  = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  tx_state_e         state_q, state_d;
  logic [WIDTH-1:0]  shiftReg_q, shiftReg_d;
  logic [BIT_W-1:0]  bitCnt_q, bitCnt_d;
  logic              rdEn_q, rdEn_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              baudClear;
  logic [BAUD_W-1:0] baudTerm;
  logic [BAUD_W-1:0] baudCnt;
  logic              baudTick;

  // The bit timer only runs from START onward; the stop phase uses the
  // longer terminal when two stop bits are configured.
  assign baudClear = (state_q == IDLE) || (state_q == FETCH);
  assign baudTerm  = (state_q == STOP) ? STOP_TERM : BIT_TERM;

  baud_tick #(
    .CNT_W (BAUD_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear_i (baudClear),
    .term_i  (baudTerm),
    .count_o (baudCnt),
    .tick_o  (baudTick)
  );

  // Next-state and next-output logic. The pop is issued from IDLE and the
  // FSM waits in IDLE for that one cycle so the FIFO data is ready in FETCH.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    rdEn_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rdEn_q) begin
          state_d = FETCH;
        end else if (bus.tx_en && !bus.fifo_empty) begin
          rdEn_d = 1'b1;
        end
      end
      FETCH: begin
        shiftReg_d = bus.fifo_dout;
        state_d    = START;
      end
      START: begin
        if (baudTick) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (baudTick) begin
          if (bitCnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            shiftReg_d = shiftReg_q >> 1;
            bitCnt_d   = bitCnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baudTick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shiftReg_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_q == STOP) && (baudCnt == STOP_PRE);
  end

  // State, datapath and output registers; reset drops the line back to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      rdEn_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      rdEn_q     <= rdEn_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.fifo_rd_en = rdEn_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ffi_ready  = ready_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance at 4 clocks/bit, 1 stop bit
// fed by a small FIFO model, and one at 16 clocks/bit, 2 stop bits.
module tb_fifo_uart_tx;

  localparam int W          = 8;
  localparam int CPB_A      = 4;
  localparam int FRAME_LAST = 2 + (1 + W + 1) * CPB_A - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.WIDTH(W)) ifA ();
  fifo_uart_tx_if #(.WIDTH(W)) ifB ();

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB_A), .STOP_BITS(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(16), .STOP_BITS(2)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  int checkCount = 0;
  int passCount  = 0;

  // FIFO model for instance A: registered read data, one cycle latency.
  logic [7:0] fifoMem [0:15];
  int wrPtr = 0;
  int rdPtr = 0;
  int popCount = 0;
  int emptyPopCount = 0;
  int backToBackPops = 0;
  logic prevRdEn = 1'b0;

  assign ifA.fifo_empty = (wrPtr == rdPtr);

  // Serve pops and note any pop on empty or on consecutive cycles.
  always @(posedge clk) begin
    if (ifA.fifo_rd_en) begin
      popCount <= popCount + 1;
      if (prevRdEn) backToBackPops <= backToBackPops + 1;
      if (wrPtr == rdPtr) begin
        emptyPopCount <= emptyPopCount + 1;
      end else begin
        ifA.fifo_dout <= fifoMem[rdPtr % 16];
        rdPtr <= rdPtr + 1;
      end
    end
    prevRdEn <= ifA.fifo_rd_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifoMem[wrPtr % 16] = b;
    wrPtr = wrPtr + 1;
  endtask

  task automatic waitRdEn(input int budget, output int waited);
    waited = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (ifA.fifo_rd_en) begin
        waited = n;
        break;
      end
    end
  endtask

  // Called at the negedge of the pop cycle (cycle 0); walks the whole frame.
  task automatic recvFrame(input logic [7:0] expByte, input int dropTxEnAt);
    int txErr = 0;
    int busyErr = 0;
    int doneErr = 0;
    int rdErr = 0;
    int bitIdx = 0;
    logic expTx;
    logic [7:0] decoded = 8'h00;
    for (int c = 1; c <= FRAME_LAST; c++) begin
      @(negedge clk);
      if (c == dropTxEnAt) ifA.tx_en = 1'b0;
      if (c < 2) begin
        expTx = 1'b1;
      end else begin
        bitIdx = (c - 2) / CPB_A;
        if (bitIdx == 0)      expTx = 1'b0;
        else if (bitIdx <= W) expTx = expByte[bitIdx-1];
        else                  expTx = 1'b1;
        if (bitIdx >= 1 && bitIdx <= W && ((c - 2) % CPB_A) == CPB_A / 2)
          decoded[bitIdx-1] = ifA.tx;
      end
      if (ifA.tx != expTx) txErr++;
      if (ifA.busy != 1'b1) busyErr++;
      if (ifA.done != (c == FRAME_LAST)) doneErr++;
      if (ifA.fifo_rd_en != 1'b0) rdErr++;
    end
    checkOutput("frameTxBits", 32'(txErr), 0);
    checkOutput("frameBusy", 32'(busyErr), 0);
    checkOutput("frameDone", 32'(doneErr), 0);
    checkOutput("frameNoPop", 32'(rdErr), 0);
    checkOutput("frameByte", 32'(decoded), 32'(expByte));
  endtask

  int waited;
  int idleErr;
  logic [7:0] seq [3];
  int firstLow, doneCycle, stopHigh, extraPops;
  logic [7:0] decB;
  bit seenB;

  initial begin
    rst = 1'b0;
    ifA.tx_en = 1'b0;
    ifB.tx_en = 1'b1;
    ifB.fifo_empty = 1'b1;
    ifB.fifo_dout = 8'h00;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rstTx", 32'(ifA.tx), 1);
    checkOutput("rstBusy", 32'(ifA.busy), 0);
    checkOutput("rstReady", 32'(ifA.ffi_ready), 1);
    checkOutput("rstRdEn", 32'(ifA.fifo_rd_en), 0);
    checkOutput("rstDone", 32'(ifA.done), 0);
    rst = 1'b1;

    // Enabled but empty: stays idle.
    ifA.tx_en = 1'b1;
    idleErr = 0;
    repeat (50) begin
      @(negedge clk);
      if (ifA.tx != 1'b1 || ifA.busy != 1'b0 || ifA.ffi_ready != 1'b1 || ifA.fifo_rd_en != 1'b0)
        idleErr++;
    end
    checkOutput("idleOutputs", 32'(idleErr), 0);
    checkOutput("idlePops", 32'(popCount), 0);

    // Single byte.
    applyStimulus(8'hA5);
    waitRdEn(10, waited);
    checkOutput("singlePop", 32'(waited != 0), 1);
    recvFrame(8'hA5, 0);
    @(negedge clk);
    checkOutput("singleIdleBusy", 32'(ifA.busy), 0);
    checkOutput("singleIdleReady", 32'(ifA.ffi_ready), 1);
    repeat (5) @(negedge clk);
    checkOutput("singlePopCount", 32'(popCount), 1);

    // Back-to-back bytes: one idle cycle between done and the next pop.
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
    for (int i = 0; i < 3; i++) applyStimulus(seq[i]);
    for (int i = 0; i < 3; i++) begin
      waitRdEn(10, waited);
      if (i == 0) checkOutput("b2bFirstPop", 32'(waited != 0), 1);
      else        checkOutput("b2bGap", 32'(waited), 2);
      recvFrame(seq[i], 0);
    end
    repeat (20) @(negedge clk);
    checkOutput("b2bPopCount", 32'(popCount), 4);
    checkOutput("b2bEmpty", 32'(ifA.fifo_empty), 1);

    // tx_en gating.
    ifA.tx_en = 1'b0;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (20) @(negedge clk);
    checkOutput("gateNoPop", 32'(popCount), 4);
    ifA.tx_en = 1'b1;
    waitRdEn(10, waited);
    checkOutput("gatePop", 32'(waited != 0), 1);
    recvFrame(8'h11, 20);
    repeat (20) @(negedge clk);
    checkOutput("gateHeld", 32'(popCount), 5);
    checkOutput("gateIdleBusy", 32'(ifA.busy), 0);
    ifA.tx_en = 1'b1;
    waitRdEn(10, waited);
    checkOutput("gateResume", 32'(waited != 0), 1);
    recvFrame(8'h22, 0);

    // Reset mid-frame during data bit 3 (0xC3 has bit 3 low).
    applyStimulus(8'hC3);
    applyStimulus(8'h5A);
    waitRdEn(10, waited);
    checkOutput("rstMidPop", 32'(waited != 0), 1);
    repeat (19) @(negedge clk);
    checkOutput("rstMidBit3", 32'(ifA.tx), 0);
    #1 rst = 1'b0;
    #1;
    checkOutput("rstMidTxAsync", 32'(ifA.tx), 1);
    checkOutput("rstMidBusy", 32'(ifA.busy), 0);
    checkOutput("rstMidReady", 32'(ifA.ffi_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    waitRdEn(10, waited);
    checkOutput("rstNextPop", 32'(waited != 0), 1);
    recvFrame(8'h5A, 0);
    repeat (5) @(negedge clk);
    checkOutput("rstPopCount", 32'(popCount), 8);
    checkOutput("noEmptyPops", 32'(emptyPopCount), 0);
    checkOutput("noB2bPops", 32'(backToBackPops), 0);

    // Two stop bits at 16 clocks per bit, byte 0x81.
    ifB.fifo_dout = 8'h81;
    ifB.fifo_empty = 1'b0;
    seenB = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ifB.fifo_rd_en) begin
        seenB = 1'b1;
        break;
      end
    end
    checkOutput("bPop", 32'(seenB), 1);
    ifB.fifo_empty = 1'b1;
    firstLow = 0; doneCycle = 0; stopHigh = 0; extraPops = 0; decB = 8'h00;
    for (int c = 1; c <= 250 && doneCycle == 0; c++) begin
      @(negedge clk);
      if (ifB.fifo_rd_en) extraPops++;
      if (ifB.tx == 1'b0 && firstLow == 0) firstLow = c;
      if (c >= 146 && ifB.tx == 1'b1) stopHigh++;
      if (c >= 18 && c < 146 && ((c - 2) % 16) == 8) decB[(c - 2) / 16 - 1] = ifB.tx;
      if (ifB.done) doneCycle = c;
    end
    checkOutput("bStartCycle", 32'(firstLow), 2);
    checkOutput("bDoneCycle", 32'(doneCycle), 177);
    checkOutput("bFrameLen", 32'(doneCycle - firstLow + 1), 176);
    checkOutput("bStopHigh", 32'(stopHigh), 32);
    checkOutput("bByte", 32'(decB), 32'h81);
    checkOutput("bExtraPops", 32'(extraPops), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
